// File: rtl/gpu_pkg.sv
// Shared definitions for the text RAM clear/scroll engine: geometry, IO
// register map, command encodings, FSM state type and a row-address helper.
package gpu_pkg;

  localparam int unsigned ADDR_W     = 12;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned TEXT_COLS  = 80;
  localparam int unsigned TEXT_ROWS  = 30;
  localparam int unsigned TEXT_CELLS = TEXT_COLS * TEXT_ROWS;

  localparam logic [ADDR_W-1:0] CTRL_ADDR = 12'h081;
  localparam logic [ADDR_W-1:0] FILL_ADDR = 12'h082;
  localparam logic [ADDR_W-1:0] ROW_ADDR  = 12'h083;

  localparam logic [1:0] CMD_NONE    = 2'b00;
  localparam logic [1:0] CMD_CLEAR   = 2'b01;
  localparam logic [1:0] CMD_SCROLL  = 2'b10;
  localparam logic [1:0] CMD_FILLROW = 2'b11;

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(TEXT_CELLS - 1);
  localparam logic [ADDR_W-1:0] LAST_COPY = ADDR_W'(TEXT_CELLS - TEXT_COLS - 1);
  localparam logic [ADDR_W-1:0] FIRST_SRC = ADDR_W'(TEXT_COLS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_COPY,
    S_FILL,
    S_DONE
  } state_e;

  // First cell address of a text row.
  function automatic logic [ADDR_W-1:0] row_base(input logic [4:0] row);
    return ADDR_W'(row) * ADDR_W'(TEXT_COLS);
  endfunction

endpackage

// File: rtl/text_wr_arbiter.sv
// Text RAM write-port arbiter: CPU glyph writes inside the screen always win
// and stall the engine; a one-entry hold register keeps copy read data that
// returned during a stall so it can be written on the next free cycle.
// Ports: clk/rst; v_w_en, cpu_addr, cpu_data (CPU side); eng_wr_* (engine
// request); rd_valid/rd_data (engine read return); stall_c, copy_avail_c,
// copy_data_c (to engine); mem_wr_* (text RAM write port, combinational).
module text_wr_arbiter
  import gpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              v_w_en,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  input  logic              eng_wr_en,
  input  logic [ADDR_W-1:0] eng_wr_addr,
  input  logic [DATA_W-1:0] eng_wr_data,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              stall_c,
  output logic              copy_avail_c,
  output logic [DATA_W-1:0] copy_data_c,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_wr_en
);

  logic              hold_valid_q, hold_valid_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;

  assign stall_c      = v_w_en && (cpu_addr < ADDR_W'(TEXT_CELLS));
  assign copy_avail_c = hold_valid_q || rd_valid;
  assign copy_data_c  = hold_valid_q ? hold_data_q : rd_data;

  assign mem_wr_en   = stall_c || eng_wr_en;
  assign mem_wr_addr = stall_c ? cpu_addr : eng_wr_addr;
  assign mem_wr_data = stall_c ? cpu_data : eng_wr_data;

  // Capture returning read data when stalled; release once it is written.
  // A read is never issued while stalled, so hold and rd_valid never overlap.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    if (stall_c && rd_valid) begin
      hold_valid_d = 1'b1;
      hold_data_d  = rd_data;
    end else if (!stall_c && hold_valid_q) begin
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
    end
  end

endmodule

// File: rtl/text_ram_engine.sv
// Clear/scroll engine for the 80x30 text RAM. Decodes the control, fill and
// (optional) row registers, sequences CLEAR / SCROLL (COPY+FILL) / FILL_ROW
// and raises done_interrupt_flag on completion when enabled.
// Optional feature macro: TEXT_ENGINE_ROWFILL_EN adds the row register at
// CTRL_ADDR+2 and command 11 (fill one row).
// Ports: clk, rst; CPU bus address/din/v_w_en/io_w_en/io_r_en; dout (IO read
// data); mem_wr_* text RAM write port; mem_rd_* engine read port with
// mem_rd_data one cycle after mem_rd_en; done_interrupt_flag and its _clr.
module text_ram_engine
  import gpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] din,
  input  logic              v_w_en,
  input  logic              io_w_en,
  input  logic              io_r_en,
  output logic [DATA_W-1:0] dout,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              done_interrupt_flag,
  input  logic              done_interrupt_flag_clr
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, end_q, end_d, rd_q, rd_d;
  logic              rd_busy_q, rd_busy_d, pend_q, pend_d;
  logic [DATA_W-1:0] fill_q, fill_d, fill_lat_q, fill_lat_d, dout_q, dout_d;
  logic              irq_en_q, irq_en_d, flag_q, flag_d, drop_q, drop_d;
`ifdef TEXT_ENGINE_ROWFILL_EN
  logic [DATA_W-1:0] row_q, row_d;
`endif

  logic              ctrl_wr_c, busy_c, cmd_drop_c, done_c, rd_en_c;
  logic              eng_we_c, stall_c, copy_avail_c;
  logic [ADDR_W-1:0] eng_addr_c;
  logic [DATA_W-1:0] eng_data_c, copy_data_c;

  assign ctrl_wr_c = io_w_en && (address == CTRL_ADDR);
  assign busy_c    = (state_q == S_CLEAR) || (state_q == S_COPY) || (state_q == S_FILL);

  text_wr_arbiter u_arb (
    .clk          (clk),
    .rst          (rst),
    .v_w_en       (v_w_en),
    .cpu_addr     (address),
    .cpu_data     (din),
    .eng_wr_en    (eng_we_c),
    .eng_wr_addr  (eng_addr_c),
    .eng_wr_data  (eng_data_c),
    .rd_valid     (pend_q),
    .rd_data      (mem_rd_data),
    .stall_c      (stall_c),
    .copy_avail_c (copy_avail_c),
    .copy_data_c  (copy_data_c),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_wr_en    (mem_wr_en)
  );

  // Sequencer: command acceptance, write/read pointers, engine requests.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    end_d      = end_q;
    rd_d       = rd_q;
    rd_busy_d  = rd_busy_q;
    fill_lat_d = fill_lat_q;
    pend_d     = 1'b0;
    rd_en_c    = 1'b0;
    eng_we_c   = 1'b0;
    eng_addr_c = cnt_q;
    eng_data_c = fill_lat_q;
    done_c     = 1'b0;
    cmd_drop_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ctrl_wr_c) begin
          case (din[1:0])
            CMD_CLEAR: begin
              state_d    = S_CLEAR;
              cnt_d      = '0;
              end_d      = LAST_CELL;
              fill_lat_d = fill_q;
            end
            CMD_SCROLL: begin
              state_d    = S_COPY;
              cnt_d      = '0;
              end_d      = LAST_CELL;
              rd_d       = FIRST_SRC;
              rd_busy_d  = 1'b1;
              fill_lat_d = fill_q;
            end
            CMD_FILLROW: begin
`ifdef TEXT_ENGINE_ROWFILL_EN
              if (row_q < DATA_W'(TEXT_ROWS)) begin
                state_d    = S_FILL;
                cnt_d      = row_base(row_q[4:0]);
                end_d      = row_base(row_q[4:0]) + ADDR_W'(TEXT_COLS - 1);
                fill_lat_d = fill_q;
              end else begin
                cmd_drop_c = 1'b1;
              end
`endif
            end
            default: ;
          endcase
        end
      end
      S_CLEAR, S_FILL: begin
        eng_we_c = 1'b1;
        if (!stall_c) begin
          if (cnt_q == end_q) state_d = S_DONE;
          else                cnt_d   = cnt_q + ADDR_W'(1);
        end
      end
      S_COPY: begin
        // Read src at t, write dst = src-80 at t+1 (from hold if stalled).
        rd_en_c  = rd_busy_q && !stall_c;
        pend_d   = rd_en_c;
        if (rd_en_c) begin
          if (rd_q == LAST_CELL) rd_busy_d = 1'b0;
          else                   rd_d      = rd_q + ADDR_W'(1);
        end
        eng_we_c   = copy_avail_c;
        eng_data_c = copy_data_c;
        if (copy_avail_c && !stall_c) begin
          cnt_d = cnt_q + ADDR_W'(1);
          if (cnt_q == LAST_COPY) state_d = S_FILL;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        done_c  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Commands arriving while the engine is not idle are dropped (sticky).
    if (ctrl_wr_c && (state_q != S_IDLE)) begin
`ifdef TEXT_ENGINE_ROWFILL_EN
      if (din[1:0] != CMD_NONE) cmd_drop_c = 1'b1;
`else
      if ((din[1:0] == CMD_CLEAR) || (din[1:0] == CMD_SCROLL)) cmd_drop_c = 1'b1;
`endif
    end
  end

  // IO registers, completion flag and registered read data.
  always_comb begin
    fill_d   = fill_q;
    irq_en_d = irq_en_q;
    flag_d   = flag_q;
    drop_d   = drop_q;
    dout_d   = dout_q;
`ifdef TEXT_ENGINE_ROWFILL_EN
    row_d    = row_q;
    if (io_w_en && (address == ROW_ADDR)) row_d = din;
`endif
    if (io_w_en && (address == FILL_ADDR)) fill_d = din;

    // Priority: acknowledge > software write > completion.
    if (done_c && irq_en_q) flag_d = 1'b1;
    if (ctrl_wr_c) begin
      flag_d   = din[3];
      irq_en_d = din[2];
    end
    if (done_interrupt_flag_clr) flag_d = 1'b0;

    // A drop in the same cycle as a status read survives the read.
    if (io_r_en && (address == CTRL_ADDR)) drop_d = 1'b0;
    if (cmd_drop_c) drop_d = 1'b1;

    if (io_r_en) begin
      case (address)
        CTRL_ADDR: dout_d = {2'b00, drop_q, 1'b0, flag_q, irq_en_q, 1'b0, busy_c};
        FILL_ADDR: dout_d = fill_q;
`ifdef TEXT_ENGINE_ROWFILL_EN
        ROW_ADDR:  dout_d = row_q;
`endif
        default:   dout_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      end_q      <= '0;
      rd_q       <= '0;
      rd_busy_q  <= 1'b0;
      pend_q     <= 1'b0;
      fill_q     <= 8'h20;
      fill_lat_q <= 8'h20;
      dout_q     <= '0;
      irq_en_q   <= 1'b0;
      flag_q     <= 1'b0;
      drop_q     <= 1'b0;
`ifdef TEXT_ENGINE_ROWFILL_EN
      row_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      end_q      <= end_d;
      rd_q       <= rd_d;
      rd_busy_q  <= rd_busy_d;
      pend_q     <= pend_d;
      fill_q     <= fill_d;
      fill_lat_q <= fill_lat_d;
      dout_q     <= dout_d;
      irq_en_q   <= irq_en_d;
      flag_q     <= flag_d;
      drop_q     <= drop_d;
`ifdef TEXT_ENGINE_ROWFILL_EN
      row_q      <= row_d;
`endif
    end
  end

  assign dout                = dout_q;
  assign done_interrupt_flag = flag_q;
  assign mem_rd_addr         = rd_q;
  assign mem_rd_en           = rd_en_c;

endmodule
